div_ratio_ctrl: RTL

- Control stage directly upstream of the clock divider.
- Accepts divide-ratio and enable requests from the register/config side over a valid/ready handshake.
- Produces the divider's ratio and clock-enable inputs, and changes the ratio only at a divided-clock period boundary while the divider is held disabled, so reconfiguration is glitch-free.
- Samples the divider output as feedback to find that boundary.

---
 rtl/div_ratio_ctrl_if.sv | 29 ++
 rtl/div_ratio_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/div_ratio_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_ratio_ctrl_if : config-side valid/ready request toward the        |
// |                     divider ratio controller                          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface div_ratio_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             i_cfg_valid;
  logic [WIDTH-1:0] i_cfg_ratio;
  logic             i_cfg_en;
  logic             o_cfg_ready;

  modport master (
    output i_cfg_valid,
    output i_cfg_ratio,
    output i_cfg_en,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_ratio,
    input  i_cfg_en,
    output o_cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/div_ratio_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_ratio_ctrl : glitch-free ratio/enable sequencer for a clock       |
// |                  divider; optional DIV_RATIO_CTRL_STATUS_EN counter   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module div_ratio_ctrl #(
  parameter int WIDTH         = 3,
  parameter int DEFAULT_RATIO = 4,
  parameter int MIN_RATIO     = 2,
  parameter int QUIET_CYC     = 2,
  parameter int TIMEOUT_CYC   = 16
) (
  input  wire              i_ref_clk,
  input  wire              i_rst,
  div_ratio_ctrl_if.slave  cfg,
  input  wire              i_div_clk,
  output logic [WIDTH-1:0] o_div_ratio,
  output logic             o_clk_en,
  output logic             o_done,
  output logic             o_err_ratio,
  output logic             o_err_timeout
`ifdef DIV_RATIO_CTRL_STATUS_EN
  ,
  output logic [7:0]       o_switch_cnt
`endif
);

  localparam int c_qw = $clog2(QUIET_CYC + 1);
  localparam int c_tw = $clog2(TIMEOUT_CYC + 1);

  localparam logic [WIDTH-1:0] c_default_ratio = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] c_min_ratio     = WIDTH'(MIN_RATIO);
  localparam logic [c_qw-1:0]  c_quiet_load    = c_qw'(QUIET_CYC - 1);
  localparam logic [c_tw-1:0]  c_timeout_last  = c_tw'(TIMEOUT_CYC - 1);

  localparam logic [1:0] c_st_off      = 2'd0;
  localparam logic [1:0] c_st_run      = 2'd1;
  localparam logic [1:0] c_st_wait_low = 2'd2;
  localparam logic [1:0] c_st_quiet    = 2'd3;

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_div_ratio, w_ratio_nxt;
  logic [WIDTH-1:0] r_lat_ratio, w_lat_ratio_nxt;
  logic             r_lat_en, w_lat_en_nxt;
  logic             r_clk_en, w_clk_en_nxt;
  logic             r_cfg_ready, w_ready_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err_ratio, w_err_ratio_nxt;
  logic             r_err_timeout, w_err_to_nxt;
  logic [c_tw-1:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic [c_qw-1:0]  r_quiet_cnt, w_quiet_cnt_nxt;
  logic             r_div_q;

  logic w_accept, w_illegal, w_noop, w_change;
  logic w_fall, w_timeout, w_quiet_exit;

  assign w_accept     = cfg.i_cfg_valid & r_cfg_ready;
  assign w_illegal    = cfg.i_cfg_ratio < c_min_ratio;
  assign w_noop       = (cfg.i_cfg_ratio == r_div_ratio) && (cfg.i_cfg_en == r_clk_en);
  assign w_change     = w_accept & ~w_illegal & ~w_noop;
  assign w_fall       = r_div_q & ~i_div_clk;
  assign w_timeout    = (r_wait_cnt == c_timeout_last) & ~w_fall;
  assign w_quiet_exit = (r_state == c_st_quiet) && (r_quiet_cnt == '0);

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_state       <= c_st_off;
      r_div_ratio   <= c_default_ratio;
      r_lat_ratio   <= c_default_ratio;
      r_lat_en      <= 1'b0;
      r_clk_en      <= 1'b0;
      r_cfg_ready   <= 1'b1;
      r_done        <= 1'b0;
      r_err_ratio   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_wait_cnt    <= '0;
      r_quiet_cnt   <= '0;
      r_div_q       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_div_ratio   <= w_ratio_nxt;
      r_lat_ratio   <= w_lat_ratio_nxt;
      r_lat_en      <= w_lat_en_nxt;
      r_clk_en      <= w_clk_en_nxt;
      r_cfg_ready   <= w_ready_nxt;
      r_done        <= w_done_nxt;
      r_err_ratio   <= w_err_ratio_nxt;
      r_err_timeout <= w_err_to_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_quiet_cnt   <= w_quiet_cnt_nxt;
      r_div_q       <= i_div_clk;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_off:      if (w_change) w_state_nxt = c_st_quiet;
      c_st_run:      if (w_change) w_state_nxt = c_st_wait_low;
      c_st_wait_low: if (w_fall || w_timeout) w_state_nxt = c_st_quiet;
      c_st_quiet:    if (w_quiet_exit) w_state_nxt = r_lat_en ? c_st_run : c_st_off;
      default:       w_state_nxt = c_st_off;
    endcase
  end

  // Ratio moves only on the QUIET entry edge, where clk_en drops in the same edge.
  always_comb begin
    w_ratio_nxt     = r_div_ratio;
    w_lat_ratio_nxt = r_lat_ratio;
    w_lat_en_nxt    = r_lat_en;
    w_clk_en_nxt    = r_clk_en;
    w_ready_nxt     = r_cfg_ready;
    w_done_nxt      = 1'b0;
    w_err_ratio_nxt = 1'b0;
    w_err_to_nxt    = 1'b0;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_quiet_cnt_nxt = r_quiet_cnt;
    case (r_state)
      c_st_off, c_st_run: begin
        if (w_accept && w_illegal) begin
          w_err_ratio_nxt = 1'b1;
        end else if (w_accept && w_noop) begin
          w_done_nxt = 1'b1;
        end else if (w_change) begin
          w_lat_ratio_nxt = cfg.i_cfg_ratio;
          w_lat_en_nxt    = cfg.i_cfg_en;
          w_ready_nxt     = 1'b0;
          if (r_state == c_st_off) begin
            w_ratio_nxt     = cfg.i_cfg_ratio;
            w_quiet_cnt_nxt = c_quiet_load;
          end else begin
            w_wait_cnt_nxt = '0;
          end
        end
      end
      c_st_wait_low: begin
        if (w_fall || w_timeout) begin
          w_ratio_nxt     = r_lat_ratio;
          w_clk_en_nxt    = 1'b0;
          w_quiet_cnt_nxt = c_quiet_load;
          w_err_to_nxt    = w_timeout;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      c_st_quiet: begin
        if (w_quiet_exit) begin
          w_clk_en_nxt = r_lat_en;
          w_ready_nxt  = 1'b1;
          w_done_nxt   = 1'b1;
        end else begin
          w_quiet_cnt_nxt = r_quiet_cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_div_ratio     = r_div_ratio;
  assign o_clk_en        = r_clk_en;
  assign cfg.o_cfg_ready = r_cfg_ready;
  assign o_done          = r_done;
  assign o_err_ratio     = r_err_ratio;
  assign o_err_timeout   = r_err_timeout;

`ifdef DIV_RATIO_CTRL_STATUS_EN
  logic [7:0] r_switch_cnt;

  // Only real reconfigurations pass through QUIET, so no-ops never count.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_switch_cnt <= 8'd0;
    end else if (w_quiet_exit && (r_switch_cnt != 8'hFF)) begin
      r_switch_cnt <= r_switch_cnt + 8'd1;
    end
  end

  assign o_switch_cnt = r_switch_cnt;
`endif

endmodule
`default_nettype wire
